// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: debounce states and per-scan results.
// Pure type definitions, no logic.
// Imported by keypad_scan.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_result_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous, idle-high (active-low) inputs.
// Latency: 2 clk cycles from a stable input to q_o.
// No handshake; samples every cycle. Resets to all-ones (the idle level).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; reset to the released (high) level of the pins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: row strobing, column sampling, per-scan debounce, key events.
// Latency: press/release accepted after DEBOUNCE_SCANS matching full scans (+ a few cycles).
// No backpressure: key_valid is a one-cycle pulse, key_code holds until the next press.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter  int ROWS           = 4,
    parameter  int COLS           = 4,
    parameter  int SETTLE_CYCLES  = 3,
    parameter  int DEBOUNCE_SCANS = 4,
    localparam int CODE_W         = $clog2(ROWS*COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COLS-1:0]   cols_n,
    output logic [ROWS-1:0]   rows_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              multi_key
);

    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CW  = $clog2(DEBOUNCE_SCANS + 1);

    // ---------------- column synchroniser ----------------
    logic [COLS-1:0] cols_n_sync;
    logic [COLS-1:0] cols;

    sync_2ff #(.WIDTH(COLS)) u_cols_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (cols_n),
        .q_o   (cols_n_sync)
    );

    assign cols = ~cols_n_sync;

    // ---------------- row sequencer ----------------
    logic [RW-1:0] row_q, row_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          sample;
    logic          last_row;

    // Next row/settle position; columns are sampled on the last settle cycle.
    always_comb begin
        sample   = (settle_q == SW'(SETTLE_CYCLES));
        last_row = (row_q == RW'(ROWS - 1));
        row_d    = row_q;
        settle_d = settle_q + 1'b1;
        if (sample) begin
            settle_d = '0;
            row_d    = last_row ? '0 : row_q + 1'b1;
        end
    end

    // Row index and settle counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            row_q    <= '0;
            settle_q <= '0;
        end else begin
            row_q    <= row_d;
            settle_q <= settle_d;
        end
    end

    // One-hot active-low strobe decoded from the row index.
    always_comb begin
        rows_n        = '1;
        rows_n[row_q] = 1'b0;
    end

    // ---------------- per-scan accumulator ----------------
    logic [1:0]        row_hits;   // saturates at 2: only "none/one/many" matters
    logic [CLW-1:0]    row_col;
    logic [CODE_W-1:0] hit_code;
    logic [2:0]        sum_raw;
    logic [1:0]        sum_cnt;
    logic [CODE_W-1:0] sum_code;

    logic [1:0]        acc_cnt_q;
    logic [CODE_W-1:0] acc_code_q;
    logic              res_vld_q;
    scan_result_t      res_q;
    logic [CODE_W-1:0] res_code_q;

    // Hits on the current row (lowest column wins) merged with earlier rows (lowest row wins).
    always_comb begin
        row_hits = 2'd0;
        row_col  = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (cols[c]) begin
                row_col = CLW'(c);
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (cols[c] && (row_hits != 2'd2)) begin
                row_hits = row_hits + 2'd1;
            end
        end
        hit_code = CODE_W'(row_q) * CODE_W'(COLS) + CODE_W'(row_col);
        sum_raw  = {1'b0, acc_cnt_q} + {1'b0, row_hits};
        sum_cnt  = (sum_raw >= 3'd2) ? 2'd2 : sum_raw[1:0];
        sum_code = (acc_cnt_q == 2'd0) ? hit_code : acc_code_q;
    end

    // Accumulate across rows; publish a one-cycle scan result after the last row.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= '0;
            res_vld_q  <= 1'b0;
            res_q      <= RES_NONE;
            res_code_q <= '0;
        end else begin
            res_vld_q <= 1'b0;
            if (sample) begin
                if (last_row) begin
                    res_vld_q  <= 1'b1;
                    res_code_q <= sum_code;
                    case (sum_cnt)
                        2'd0:    res_q <= RES_NONE;
                        2'd1:    res_q <= RES_SINGLE;
                        default: res_q <= RES_MULTI;
                    endcase
                    acc_cnt_q  <= 2'd0;
                    acc_code_q <= '0;
                end else begin
                    acc_cnt_q  <= sum_cnt;
                    acc_code_q <= sum_code;
                end
            end
        end
    end

    // ---------------- debounce FSM ----------------
    scan_state_t       state_q;
    logic [CW-1:0]     cnt_q;
    logic [CODE_W-1:0] cand_q;
    logic [CODE_W-1:0] key_code_q;
    logic              key_valid_q;
    logic              key_held_q;
    logic              multi_q;

    // Scan-granular debounce with rollover lock; all outputs registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (res_vld_q) begin
                multi_q <= (res_q == RES_MULTI);
            end
            case (state_q)
                IDLE: begin
                    if (res_vld_q && (res_q == RES_SINGLE)) begin
                        state_q <= PRESS_WAIT;
                        cand_q  <= res_code_q;
                        cnt_q   <= CW'(1);
                    end
                end
                PRESS_WAIT: begin
                    // Count reached on the previous result: accept without waiting a scan.
                    if (cnt_q == CW'(DEBOUNCE_SCANS)) begin
                        state_q     <= HELD;
                        key_code_q  <= cand_q;
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        cnt_q       <= '0;
                    end else if (res_vld_q) begin
                        if (res_q == RES_SINGLE) begin
                            if (res_code_q == cand_q) begin
                                cnt_q <= cnt_q + 1'b1;
                            end else begin
                                cand_q <= res_code_q;
                                cnt_q  <= CW'(1);
                            end
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                end
                HELD: begin
                    if (res_vld_q) begin
                        if (res_q == RES_NONE) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                state_q    <= IDLE;
                                key_held_q <= 1'b0;
                                cnt_q      <= '0;
                            end else begin
                                state_q <= RELEASE_WAIT;
                                cnt_q   <= CW'(1);
                            end
                        end else if ((res_q == RES_SINGLE) && (res_code_q != key_code_q)) begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= CW'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (res_vld_q) begin
                        if (res_q == RES_NONE) begin
                            if (cnt_q >= CW'(DEBOUNCE_SCANS - 1)) begin
                                state_q    <= IDLE;
                                key_held_q <= 1'b0;
                                cnt_q      <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else if ((res_q == RES_MULTI) || (res_code_q == key_code_q)) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= CW'(1);
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    key_held_q <= 1'b0;
                    cnt_q      <= '0;
                end
            endcase
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key matrix.
// Outputs sampled on the falling clock edge; pulse monitor samples 2 time units after the rising edge.
// Expected values are hand-derived from the scan/debounce timing.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cols_n;
    logic [3:0]  rows_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        multi_key;
    logic [15:0] keys;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int doubles = 0;
    logic prev_v = 1'b0;

    always #5 clk = ~clk;

    // Key matrix: a pressed key shorts its row strobe onto its column line.
    always_comb begin
        cols_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rows_n[r] && keys[r*4 + c]) begin
                    cols_n[c] = 1'b0;
                end
            end
        end
    end

    keypad_scan #(
        .ROWS           (4),
        .COLS           (4),
        .SETTLE_CYCLES  (3),
        .DEBOUNCE_SCANS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols_n    (cols_n),
        .rows_n    (rows_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    // Count key_valid pulses and back-to-back pulses.
    always @(posedge clk) begin
        #2;
        if (key_valid) begin
            pulses++;
            if (prev_v) doubles++;
        end
        prev_v = key_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int max, output int lat);
        int p0;
        p0  = pulses;
        lat = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (pulses > p0) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_held_low(input int max, output int lat);
        lat = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!key_held) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int p0;
        int r;
        logic [3:0] e;
        logic seen;

        keys  = 16'h0000;
        reset = 1'b0;
        cycles(3);
        check("rst_rows", rows_n, 4'b1110);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_multi", multi_key, 0);

        // Free-running scan: row 0 already strobed during reset, so 3 more cycles of it.
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            r    = ((i + 1) / 4) % 4;
            e    = 4'hF;
            e[r] = 1'b0;
            check("scan_rows", rows_n, e);
        end
        p0 = pulses;
        cycles(200);
        check("idle_no_pulse", pulses - p0, 0);
        check("idle_held", key_held, 0);
        check("idle_multi", multi_key, 0);

        // Single key 9 (row 2, col 1).
        p0 = pulses;
        keys[9] = 1'b1;
        wait_pulse(83, lat);
        check("k9_found", (lat >= 0), 1);
        check("k9_code", key_code, 9);
        check("k9_valid", key_valid, 1);
        check("k9_held", key_held, 1);
        cycles(100);
        check("k9_one_pulse", pulses - p0, 1);
        check("k9_still_held", key_held, 1);
        check("k9_valid_low", key_valid, 0);
        check("k9_multi", multi_key, 0);
        keys = 16'h0000;
        wait_held_low(83, lat);
        check("k9_release", (lat >= 0), 1);
        check("k9_code_kept", key_code, 9);
        check("k9_no_release_pulse", pulses - p0, 1);

        // Bounce: 20-cycle on/off toggling never gives 4 matching scans.
        p0 = pulses;
        for (int k = 0; k < 8; k++) begin
            keys[9] = ((k % 2) == 0);
            cycles((k == 7) ? 10 : 20);
        end
        check("bounce_no_pulse", pulses - p0, 0);
        keys[9] = 1'b1;
        wait_pulse(83, lat);
        check("bounce_hold_found", (lat >= 0), 1);
        check("bounce_code", key_code, 9);
        check("bounce_one_pulse", pulses - p0, 1);
        keys = 16'h0000;
        wait_held_low(83, lat);
        check("bounce_release", (lat >= 0), 1);

        // Two keys (5 and 10) down together.
        p0 = pulses;
        keys[5]  = 1'b1;
        keys[10] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (multi_key) begin
                seen = 1'b1;
                break;
            end
        end
        check("multi_seen", seen, 1);
        cycles(80);
        check("multi_no_pulse", pulses - p0, 0);
        check("multi_not_held", key_held, 0);
        check("multi_level", multi_key, 1);
        keys[10] = 1'b0;
        wait_pulse(83, lat);
        check("multi_k5_found", (lat >= 0), 1);
        check("multi_k5_code", key_code, 5);
        check("multi_k5_one", pulses - p0, 1);
        check("multi_cleared", multi_key, 0);
        keys = 16'h0000;
        wait_held_low(83, lat);
        check("multi_release", (lat >= 0), 1);

        // Rollover lock: 3 accepted, then 12 added, then 3 released.
        keys[3] = 1'b1;
        wait_pulse(83, lat);
        check("roll_k3_found", (lat >= 0), 1);
        check("roll_k3_code", key_code, 3);
        p0 = pulses;
        keys[12] = 1'b1;
        cycles(100);
        check("roll_both_no_pulse", pulses - p0, 0);
        check("roll_both_held", key_held, 1);
        check("roll_both_multi", multi_key, 1);
        keys[3] = 1'b0;
        cycles(150);
        check("roll_k12_no_pulse", pulses - p0, 0);
        check("roll_k12_held", key_held, 1);
        check("roll_k12_code", key_code, 3);
        keys = 16'h0000;
        wait_held_low(83, lat);
        check("roll_release", (lat >= 0), 1);
        check("roll_release_no_pulse", pulses - p0, 0);
        keys[12] = 1'b1;
        wait_pulse(83, lat);
        check("roll_repress_found", (lat >= 0), 1);
        check("roll_repress_code", key_code, 12);
        keys = 16'h0000;
        wait_held_low(83, lat);
        check("roll_repress_release", (lat >= 0), 1);

        // Reset during PRESS_WAIT of key 7 discards the partial debounce.
        keys[7] = 1'b1;
        cycles(40);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_rows", rows_n, 4'b1110);
        check("mid_rst_code", key_code, 0);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_held", key_held, 0);
        check("mid_rst_multi", multi_key, 0);
        reset = 1'b1;
        p0 = pulses;
        cycles(60);
        check("mid_rst_fresh_count", pulses - p0, 0);
        wait_pulse(30, lat);
        check("mid_rst_k7_found", (lat >= 0), 1);
        check("mid_rst_k7_code", key_code, 7);
        keys = 16'h0000;
        cycles(5);

        check("no_back_to_back", doubles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
